cheat_engine: RTL and testbench

CHEAT_ENGINE -- requirements
Module: cheat_engine

---
 rtl/cheat_pkg.sv | 21 ++
 rtl/cheat_frame_rx.sv | 47 ++++
 rtl/cheat_engine.sv | 189 ++++++++++++++++++
 tb/tb_cheat_engine.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cheat_pkg.sv
// ============================================================================
//  cheat_pkg : shared types and constants for the cheat-code engine
//  Revision  : 1.0
// ============================================================================
`default_nettype none

package cheat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam int FRAME_BYTES = 16;
  localparam int FLAG_CMP    = 0;
  localparam int FLAG_DEL    = 1;

endpackage

`default_nettype wire

// File: rtl/cheat_frame_rx.sv
// ============================================================================
//  cheat_frame_rx : assembles the 16-byte big-endian load frame, length check
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module cheat_frame_rx
  import cheat_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     accept,
  input  logic [7:0]               ld_byte,
  input  logic                     ld_last,
  output logic [8*FRAME_BYTES-1:0] frame,
  output logic                     frame_valid,
  output logic                     len_err
);

  localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

  // Only the first 15 bytes are stored; the 16th is taken straight off the bus.
  logic [8*(FRAME_BYTES-1)-1:0] r_shift;
  logic [3:0]                   r_cnt;
  logic                         w_final;

  assign w_final     = (r_cnt == LAST_BYTE);
  assign frame       = {r_shift, ld_byte};
  assign frame_valid = accept & ~clear & w_final & ld_last;
  assign len_err     = accept & ~clear & (w_final ^ ld_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (accept) begin
      r_shift <= {r_shift[8*(FRAME_BYTES-2)-1:0], ld_byte};
      r_cnt   <= (w_final | ld_last) ? 4'd0 : r_cnt + 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cheat_engine.sv
// ============================================================================
//  cheat_engine : address/data override table with serial frame loader
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module cheat_engine
  import cheat_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_CODES  = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           clear_all,
  input  logic                           ld_valid,
  input  logic [7:0]                     ld_byte,
  input  logic                           ld_last,
  output logic                           ld_ready,
  output logic                           busy,
  output logic                           err,
  output logic [$clog2(MAX_CODES+1)-1:0] code_count,
  output logic                           full,
  input  logic [ADDR_WIDTH-1:0]          addr_in,
  input  logic [DATA_WIDTH-1:0]          data_in,
  output logic                           genie_ovr,
  output logic [DATA_WIDTH-1:0]          genie_data
);

  localparam int IDX_W = $clog2(MAX_CODES);
  localparam int CNT_W = $clog2(MAX_CODES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_CODES - 1);

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_dup_hit, r_free_hit;
  logic [IDX_W-1:0]        r_dup_idx, r_free_idx;
  logic                    r_f_cmp_en, r_f_del;
  logic [ADDR_WIDTH-1:0]   r_f_addr;
  logic [DATA_WIDTH-1:0]   r_f_cmp, r_f_rep;
  logic                    r_err;
  logic [MAX_CODES-1:0]    r_valid;
  logic [CNT_W-1:0]        r_count;

  logic [MAX_CODES-1:0]    r_cmp_en;
  logic [ADDR_WIDTH-1:0]   r_addr [MAX_CODES];
  logic [DATA_WIDTH-1:0]   r_cmp  [MAX_CODES];
  logic [DATA_WIDTH-1:0]   r_rep  [MAX_CODES];

  logic [8*FRAME_BYTES-1:0] w_frame;
  logic                     w_frame_valid, w_len_err, w_accept;
  logic                     w_wr_en;
  logic [IDX_W-1:0]         w_wr_idx;
  logic                     w_hit;
  logic [DATA_WIDTH-1:0]    w_hit_data;
  logic                     w_unused;

  assign ld_ready   = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign err        = r_err;
  assign code_count = r_count;
  assign full       = (r_count == CNT_W'(MAX_CODES));
  assign w_accept   = ld_valid & ld_ready;
  assign w_unused   = ^w_frame;

  cheat_frame_rx u_frame_rx (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear_all),
    .accept      (w_accept),
    .ld_byte     (ld_byte),
    .ld_last     (ld_last),
    .frame       (w_frame),
    .frame_valid (w_frame_valid),
    .len_err     (w_len_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_dup_hit  <= 1'b0;
      r_dup_idx  <= '0;
      r_free_hit <= 1'b0;
      r_free_idx <= '0;
      r_f_cmp_en <= 1'b0;
      r_f_del    <= 1'b0;
      r_f_addr   <= '0;
      r_f_cmp    <= '0;
      r_f_rep    <= '0;
      r_err      <= 1'b0;
      r_valid    <= '0;
      r_count    <= '0;
    end else begin
      r_err <= 1'b0;
      if (clear_all) begin
        r_state <= ST_IDLE;
        r_valid <= '0;
        r_count <= '0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_idx      <= '0;
            r_dup_hit  <= 1'b0;
            r_free_hit <= 1'b0;
            if (w_len_err) r_err <= 1'b1;
            if (w_frame_valid) begin
              r_f_cmp_en <= w_frame[96 + FLAG_CMP];
              r_f_del    <= w_frame[96 + FLAG_DEL];
              r_f_addr   <= w_frame[64 +: ADDR_WIDTH];
              r_f_cmp    <= w_frame[32 +: DATA_WIDTH];
              r_f_rep    <= w_frame[0  +: DATA_WIDTH];
              r_state    <= ST_SEARCH;
            end
          end
          ST_SEARCH: begin
            if (r_valid[r_idx] && (r_addr[r_idx] == r_f_addr) && !r_dup_hit) begin
              r_dup_hit <= 1'b1;
              r_dup_idx <= r_idx;
            end
            if (!r_valid[r_idx] && !r_free_hit) begin
              r_free_hit <= 1'b1;
              r_free_idx <= r_idx;
            end
            if (r_idx == LAST_IDX) r_state <= ST_COMMIT;
            else                   r_idx   <= r_idx + 1'b1;
          end
          ST_COMMIT: begin
            r_state <= ST_IDLE;
            if (r_dup_hit) begin
              if (r_f_del) begin
                r_valid[r_dup_idx] <= 1'b0;
                r_count            <= r_count - 1'b1;
              end
            end else if (!r_f_del) begin
              if (r_free_hit) begin
                r_valid[r_free_idx] <= 1'b1;
                r_count             <= r_count + 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Payload storage needs no reset: an entry is only observed through its valid bit.
  assign w_wr_en  = (r_state == ST_COMMIT) && !clear_all && !r_f_del && (r_dup_hit || r_free_hit);
  assign w_wr_idx = r_dup_hit ? r_dup_idx : r_free_idx;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_cmp_en[w_wr_idx] <= r_f_cmp_en;
      r_addr[w_wr_idx]   <= r_f_addr;
      r_cmp[w_wr_idx]    <= r_f_cmp;
      r_rep[w_wr_idx]    <= r_f_rep;
    end
  end

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int i = MAX_CODES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_addr[i] == addr_in) && (!r_cmp_en[i] || (r_cmp[i] == data_in))) begin
        w_hit      = 1'b1;
        w_hit_data = r_rep[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      genie_ovr  <= 1'b0;
      genie_data <= '0;
    end else begin
      genie_ovr  <= enable & w_hit;
      genie_data <= (enable & w_hit) ? w_hit_data : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cheat_engine.sv
// ============================================================================
//  tb_cheat_engine : directed self-checking bench for cheat_engine
//  Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_cheat_engine;
  localparam int AW = 24;
  localparam int DW = 8;
  localparam int MC = 32;
  localparam int CW = $clog2(MC + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          clear_all = 1'b0;
  logic          ld_valid = 1'b0;
  logic [7:0]    ld_byte = 8'h00;
  logic          ld_last = 1'b0;
  logic          ld_ready, busy, err, full;
  logic [CW-1:0] code_count;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] data_in = '0;
  logic          genie_ovr;
  logic [DW-1:0] genie_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cheat_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_CODES(MC)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .clear_all  (clear_all),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .busy       (busy),
    .err        (err),
    .code_count (code_count),
    .full       (full),
    .addr_in    (addr_in),
    .data_in    (data_in),
    .genie_ovr  (genie_ovr),
    .genie_data (genie_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drives n bytes of f (MSB first); returns err sampled after the last accept.
  task automatic send_bytes(input logic [127:0] f, input int n, input bit last, output bit err_seen);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_byte  = f[127 - 8*i -: 8];
      ld_last  = last && (i == n - 1);
    end
    @(negedge clk);
    err_seen = err;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic load(input string tag, input logic [31:0] flags, input logic [31:0] addr,
                      input logic [31:0] cmpv, input logic [31:0] rep, input bit exp_err);
    bit e;
    int cyc = 0;
    send_bytes({flags, addr, cmpv, rep}, 16, 1'b1, e);
    check({tag, " rx_err"}, 64'(e), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd1);
    while (!ld_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(MC + 1));
    check({tag, " commit_err"}, 64'(err), 64'(exp_err));
  endtask

  task automatic lookup(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit exp_ovr, input logic [DW-1:0] exp_data);
    @(negedge clk);
    addr_in = a;
    data_in = d;
    @(negedge clk);
    check({tag, " ovr"}, 64'(genie_ovr), 64'(exp_ovr));
    check({tag, " data"}, 64'(genie_data), 64'(exp_data));
  endtask

  initial begin
    bit e;
    repeat (3) @(negedge clk);
    check("rst ld_ready", 64'(ld_ready), 64'd1);
    check("rst busy", 64'(busy), 64'd0);
    check("rst full", 64'(full), 64'd0);
    check("rst count", 64'(code_count), 64'd0);
    check("rst ovr", 64'(genie_ovr), 64'd0);
    check("rst err", 64'(err), 64'd0);
    reset  = 1'b0;
    enable = 1'b1;

    // Plain add, then lookup hit / miss / disabled
    load("addA", 32'h0, 32'h00C123, 32'h0, 32'hEA, 1'b0);
    check("addA count", 64'(code_count), 64'd1);
    lookup("hitA", 24'h00C123, 8'h00, 1'b1, 8'hEA);
    lookup("missA", 24'h00C124, 8'h00, 1'b0, 8'h00);
    enable = 1'b0;
    lookup("disA", 24'h00C123, 8'h00, 1'b0, 8'h00);
    enable = 1'b1;

    // Compare-enabled code
    load("addB", 32'h1, 32'h7E0010, 32'h10, 32'h55, 1'b0);
    check("addB count", 64'(code_count), 64'd2);
    lookup("B cmp miss", 24'h7E0010, 8'h11, 1'b0, 8'h00);
    lookup("B cmp hit", 24'h7E0010, 8'h10, 1'b1, 8'h55);

    // Delete present and absent
    load("delB", 32'h2, 32'h7E0010, 32'h0, 32'h0, 1'b0);
    check("delB count", 64'(code_count), 64'd1);
    lookup("B gone", 24'h7E0010, 8'h10, 1'b0, 8'h00);
    load("delX", 32'h2, 32'h123456, 32'h0, 32'h0, 1'b0);
    check("delX count", 64'(code_count), 64'd1);

    // Overwrite in place; ignored high flag bits
    load("ovwA", 32'hFFFF_FFFC, 32'h00C123, 32'h0, 32'h77, 1'b0);
    check("ovwA count", 64'(code_count), 64'd1);
    lookup("hitA2", 24'h00C123, 8'h33, 1'b1, 8'h77);

    // Length errors: early ld_last, then 16 bytes with no ld_last
    send_bytes({32'h0, 32'h000001, 32'h0, 32'h01}, 10, 1'b1, e);
    check("early last err", 64'(e), 64'd1);
    check("early last ready", 64'(ld_ready), 64'd1);
    send_bytes({32'h0, 32'h000001, 32'h0, 32'h01}, 16, 1'b0, e);
    check("no last err", 64'(e), 64'd1);
    check("no last count", 64'(code_count), 64'd1);
    load("addC", 32'h0, 32'h000001, 32'h0, 32'h01, 1'b0);
    check("addC count", 64'(code_count), 64'd2);
    lookup("hitC", 24'h000001, 8'h00, 1'b1, 8'h01);

    // Fill the table, overflow, then overwrite while full
    for (int i = 0; i < MC - 2; i++)
      load("fill", 32'h0, 32'h100000 + 32'(i), 32'h0, 32'(i + 8'h80), 1'b0);
    check("fill count", 64'(code_count), 64'(MC));
    check("fill full", 64'(full), 64'd1);
    lookup("hit fill", 24'h100005, 8'h00, 1'b1, 8'h85);
    load("overflow", 32'h0, 32'h2ABCDE, 32'h0, 32'h66, 1'b1);
    check("overflow count", 64'(code_count), 64'(MC));
    lookup("overflow miss", 24'h2ABCDE, 8'h00, 1'b0, 8'h00);
    load("ovwA full", 32'h0, 32'h00C123, 32'h0, 32'h99, 1'b0);
    lookup("hitA3", 24'h00C123, 8'h00, 1'b1, 8'h99);

    // clear_all during SEARCH
    send_bytes({32'h0, 32'h333333, 32'h0, 32'h33}, 16, 1'b1, e);
    repeat (3) @(negedge clk);
    check("pre-clear busy", 64'(busy), 64'd1);
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    check("clr ready", 64'(ld_ready), 64'd1);
    check("clr busy", 64'(busy), 64'd0);
    check("clr count", 64'(code_count), 64'd0);
    check("clr full", 64'(full), 64'd0);
    lookup("clr A", 24'h00C123, 8'h00, 1'b0, 8'h00);
    repeat (MC + 2) @(negedge clk);
    lookup("clr frame", 24'h333333, 8'h00, 1'b0, 8'h00);

    // Reset mid-frame
    load("addD", 32'h0, 32'h444444, 32'h0, 32'h44, 1'b0);
    lookup("hitD", 24'h444444, 8'h00, 1'b1, 8'h44);
    send_bytes({32'h0, 32'h666666, 32'h0, 32'h66}, 8, 1'b0, e);
    #2 reset = 1'b1;
    #1;
    check("mid rst count", 64'(code_count), 64'd0);
    check("mid rst ready", 64'(ld_ready), 64'd1);
    check("mid rst ovr", 64'(genie_ovr), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    lookup("rst D", 24'h444444, 8'h00, 1'b0, 8'h00);
    load("addE", 32'h0, 32'h555555, 32'h0, 32'h5A, 1'b0);
    check("addE count", 64'(code_count), 64'd1);
    lookup("hitE", 24'h555555, 8'h00, 1'b1, 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
